// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the execute-stage control and mult_div_unit.
// The master side issues operations and MTHI/MTLO writes; the slave side
// (the unit itself) returns busy/done status and the HI/LO registers.
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  writeHi;
    logic                  writeLo;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  busy;
    logic                  done;
    logic                  divByZero;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, writeHi, writeLo, writeData,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
        input  start, op, a, b, writeHi, writeLo, writeData,
        output busy, done, divByZero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit with HI/LO registers (MULT, MULTU,
// DIV, DIVU, MTHI, MTLO). One multiplier/quotient bit per cycle; latency is
// DATA_WIDTH+1 edges, or one edge for a divide by zero.
// Optional feature: define MULT_DIV_SIGNED_EN to make op[0] select signed
// MULT/DIV; without it op[0] is ignored and every op runs unsigned.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic              clock,
    input  logic              nReset,
    mult_div_unit_if.slave    bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

`ifdef MULT_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [2*W-1:0]     acc;        // MUL: {partial hi, multiplier}; DIV: {remainder, dividend/quotient}
    logic [W-1:0]       operand;    // multiplicand magnitude or divisor magnitude
    logic               neg_lo;     // negate product / quotient at FIX
    logic               neg_hi;     // negate remainder at FIX
    logic               is_div;
    logic               zero_div;
    logic [W-1:0]       hi_q;
    logic [W-1:0]       lo_q;
    logic               done_q;
    logic               dz_q;

    // Operand sign handling; folds to plain unsigned when signed ops are disabled.
    logic               signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [W-1:0]       a_mag;
    logic [W-1:0]       b_mag;
    logic               b_zero;

    // Per-iteration datapath and FIX-stage sign correction.
    logic [W:0]         mul_sum;
    logic [2*W-1:0]     mul_next;
    logic [W:0]         div_shift;
    logic [W:0]         div_diff;
    logic [2*W-1:0]     div_next;
    logic [2*W-1:0]     prod_fix;
    logic [W-1:0]       quo_fix;
    logic [W-1:0]       rem_fix;

    // Operand magnitudes and sign flags derived from the live inputs.
    always_comb begin
        signed_op = SIGNED_EN & bus.op[0];
        a_neg     = signed_op & bus.a[W-1];
        b_neg     = signed_op & bus.b[W-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        b_zero    = (bus.b == '0);
    end

    // One shift-add or restoring shift-subtract step, plus FIX-stage results.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
        mul_next  = acc[0] ? {mul_sum, acc[W-1:1]}
                           : {1'b0, acc[2*W-1:W], acc[W-1:1]};
        // A borrow out of the (W+1)-bit subtract means the divisor did not fit.
        div_shift = acc[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, operand};
        div_next  = div_diff[W] ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  acc[W-2:0], 1'b1};
        prod_fix  = neg_lo ? -acc : acc;
        quo_fix   = neg_lo ? -acc[W-1:0]     : acc[W-1:0];
        rem_fix   = neg_hi ? -acc[2*W-1:W]   : acc[2*W-1:W];
    end

    // State register.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state decode and busy output.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        bus.busy   = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    if (!bus.op[1]) next_state = MUL;
                    else if (b_zero) next_state = FIX;
                    else             next_state = DIV;
                end
            end
            MUL, DIV: if (cnt == LAST_ITER) next_state = FIX;
            FIX:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Operand capture, iteration, result write-back and MTHI/MTLO writes.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            cnt      <= '0;
            acc      <= '0;
            operand  <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            is_div   <= 1'b0;
            zero_div <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.writeHi) hi_q <= bus.writeData;
                if (bus.writeLo) lo_q <= bus.writeData;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt      <= '0;
                        is_div   <= bus.op[1];
                        zero_div <= bus.op[1] & b_zero;
                        neg_lo   <= a_neg ^ b_neg;
                        if (bus.op[1]) begin
                            operand <= b_mag;
                            neg_hi  <= a_neg;
                            // Divide by zero reports the raw dividend in HI.
                            acc     <= b_zero ? {{W{1'b0}}, bus.a} : {{W{1'b0}}, a_mag};
                        end else begin
                            operand <= a_mag;
                            neg_hi  <= 1'b0;
                            acc     <= {{W{1'b0}}, b_mag};
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    done_q <= 1'b1;
                    dz_q   <= zero_div;
                    if (zero_div) begin
                        hi_q <= acc[W-1:0];
                        lo_q <= '1;
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.divByZero = dz_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (DATA_WIDTH=32): directed cases plus
// randomized ops against an arithmetic reference model. Honours
// MULT_DIV_SIGNED_EN the same way as the design.
module tb_mult_div_unit;
    localparam int W = 32;

`ifdef MULT_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic nReset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mult_div_unit_if #(.DATA_WIDTH(W)) bus ();

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        bit     sgn;
        longint sa, sb, q, r;
        logic [63:0] p;
        sgn = SIGNED_EN && op[0];
        dz  = 1'b0;
        if (!op[1]) begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            hi = a;
            lo = '1;
            dz = 1'b1;
        end else begin
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'b0, a});
                sb = longint'({32'b0, b});
            end
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    // Issue one op from the current (idle) cycle and check timing and results.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp_hi, exp_lo, base_hi, base_lo;
        logic         exp_dz;
        int           edges, busy_cycles;
        bit           stable;
        model(op, a, b, exp_hi, exp_lo, exp_dz);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check({tag, "_done_clear"}, 64'(bus.done), 64'd0);
        base_hi = bus.hi;
        base_lo = bus.lo;
        edges = 0;
        busy_cycles = 0;
        stable = 1'b1;
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cycles++;
            if (bus.hi !== base_hi || bus.lo !== base_lo) stable = 1'b0;
            @(posedge clock); #1;
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), exp_dz ? 64'd1 : 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), exp_dz ? 64'd1 : 64'd33);
        check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
        check({tag, "_dz"}, 64'(bus.divByZero), 64'(exp_dz));
        check({tag, "_stable"}, 64'(stable), 64'd1);
    endtask

    initial begin : stimulus
        logic [W-1:0] e_hi, e_lo;
        logic         e_dz;
        int           n_done;
        logic [1:0]   rop;
        logic [W-1:0] ra, rb;

        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.writeHi = 1'b0;
        bus.writeLo = 1'b0;
        bus.writeData = '0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.divByZero), 64'd0);
        @(negedge clock);
        nReset = 1'b1;
        @(posedge clock); #1;

        // Directed arithmetic cases.
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7);
        check("divu_100_7_lo_const", 64'(bus.lo), 64'd14);
        run_op("div_zero", 2'b11, 32'h0000_1234, 32'd0);
        run_op("multu_after_dz", 2'b00, 32'd2, 32'd3);
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);

        // Second start at E5 is ignored; exactly one done with the first result.
        model(2'b10, 32'd1000, 32'd33, e_hi, e_lo, e_dz);
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.a = 32'd1000;
        bus.b = 32'd33;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd9;
        bus.b = 32'd9;
        @(posedge clock); #1;
        bus.start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                n_done++;
                check("ignore_start_hi", 64'(bus.hi), 64'(e_hi));
                check("ignore_start_lo", 64'(bus.lo), 64'(e_lo));
            end
            @(posedge clock); #1;
        end
        check("ignore_start_ndone", 64'(n_done), 64'd1);

        // Reset asserted at E10 of a DIVU aborts it immediately.
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.a = 32'd5000;
        bus.b = 32'd3;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        nReset = 1'b0;
        #1;
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_dz", 64'(bus.divByZero), 64'd0);
        @(negedge clock);
        @(negedge clock);
        nReset = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        run_op("multu_7x6", 2'b00, 32'd7, 32'd6);

        // MTHI while idle, MTLO while busy.
        bus.writeHi = 1'b1;
        bus.writeData = 32'hCAFE_F00D;
        @(posedge clock); #1;
        bus.writeHi = 1'b0;
        check("mthi_idle", 64'(bus.hi), 64'hCAFE_F00D);
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd11;
        bus.b = 32'd13;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.writeLo = 1'b1;
        bus.writeData = 32'h1234_5678;
        @(posedge clock); #1;
        bus.writeLo = 1'b0;
        check("mtlo_busy", 64'(bus.lo), 64'd42);
        n_done = 0;
        for (int i = 0; i < 40 && !bus.done; i++) begin
            @(posedge clock); #1;
        end
        check("mtlo_busy_result", 64'(bus.lo), 64'd143);

        // MTLO together with start: write lands now, result overwrites later.
        bus.writeLo = 1'b1;
        bus.writeData = 32'h5555_AAAA;
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd4;
        bus.b = 32'd5;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.writeLo = 1'b0;
        check("mtlo_start_now", 64'(bus.lo), 64'h5555_AAAA);
        for (int i = 0; i < 40 && !bus.done; i++) begin
            @(posedge clock); #1;
        end
        check("mtlo_start_result", 64'(bus.lo), 64'd20);

        // Randomized back-to-back ops (each start issued in the done cycle).
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
